// File: rtl/apwm_temp_monitor.sv
// Block-averaging temperature monitor for APWM duty codes. It provides a hysteretic warning,
// a latched over-temperature fault, a stream-loss watchdog and a combined trip output.
module apwm_temp_monitor #(
    parameter int DW       = 10,
    parameter int AVG_LOG2 = 3,
    parameter int WARN_ON  = 700,
    parameter int WARN_OFF = 650,
    parameter int FAULT_ON = 850,
    parameter int DEBOUNCE = 4,
    parameter int TIMEOUT  = 2000000,
    parameter int TW       = 22
) (
    input  logic          CLK,
    input  logic          iRST,
    input  logic [DW-1:0] iDuty,
    input  logic          iDuty_valid,
    input  logic          iClear,
    output logic [DW-1:0] oTemp,
    output logic          oTemp_valid,
    output logic          oWarn,
    output logic          oFault,
    output logic          oLost,
    output logic          oTrip
);
    localparam int AW  = DW + AVG_LOG2;
    localparam int DBW = $clog2(DEBOUNCE + 1);
    localparam logic [DW-1:0]  WARN_ON_C  = DW'(WARN_ON);
    localparam logic [DW-1:0]  WARN_OFF_C = DW'(WARN_OFF);
    localparam logic [DW-1:0]  FAULT_ON_C = DW'(FAULT_ON);
    localparam logic [DBW-1:0] DB_LAST    = DBW'(DEBOUNCE - 1);
    localparam logic [DBW-1:0] DB_MAX     = DBW'(DEBOUNCE);
    localparam logic [TW-1:0]  TIMEOUT_C  = TW'(TIMEOUT);

    typedef enum logic {NORMAL, WARN} state_e;

    logic [AW-1:0]       acc_q;
    logic [AVG_LOG2-1:0] cnt_q;
    logic [DW-1:0]       temp_q;
    logic                temp_valid_q;
    logic [TW-1:0]       wd_q;
    logic                lost_q;
    logic                seen_q;
    state_e              state_q;
    logic [DBW-1:0]      wcnt_q;
    logic [DBW-1:0]      fcnt_q;
    logic                fault_q;

    logic [AW-1:0] sum_d;
    logic          loss_d;
    logic          fault_set_d;

    assign sum_d       = acc_q + AW'(iDuty);
    // A strobe on the timeout cycle restarts the watchdog, so it suppresses the loss.
    assign loss_d      = !iDuty_valid && (wd_q == TIMEOUT_C - TW'(1));
    assign fault_set_d = temp_valid_q && (temp_q >= FAULT_ON_C) && (fcnt_q >= DB_LAST);

    always_ff @(posedge CLK or negedge iRST) begin
        if (!iRST) begin
            acc_q        <= '0;
            cnt_q        <= '0;
            temp_q       <= '0;
            temp_valid_q <= 1'b0;
        end else begin
            temp_valid_q <= 1'b0;
            if (iDuty_valid) begin
                if (cnt_q == '1) begin
                    temp_q       <= sum_d[AW-1:AVG_LOG2];
                    temp_valid_q <= 1'b1;
                    acc_q        <= '0;
                    cnt_q        <= '0;
                end else begin
                    acc_q <= sum_d;
                    cnt_q <= cnt_q + 1'b1;
                end
            end else if (loss_d) begin
                acc_q <= '0;
                cnt_q <= '0;
            end
        end
    end

    always_ff @(posedge CLK or negedge iRST) begin
        if (!iRST) begin
            wd_q   <= '0;
            lost_q <= 1'b0;
            seen_q <= 1'b0;
        end else begin
            if (iDuty_valid) begin
                wd_q <= '0;
            end else if (wd_q != TIMEOUT_C) begin
                wd_q <= wd_q + 1'b1;
            end
            if (loss_d) begin
                lost_q <= 1'b1;
                seen_q <= 1'b0;
            end else begin
                if (iDuty_valid) begin
                    seen_q <= 1'b1;
                end
                if (iClear && seen_q) begin
                    lost_q <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge iRST) begin
        if (!iRST) begin
            state_q <= NORMAL;
            wcnt_q  <= '0;
        end else if (temp_valid_q) begin
            case (state_q)
                NORMAL: begin
                    if (temp_q >= WARN_ON_C) begin
                        if (wcnt_q >= DB_LAST) begin
                            state_q <= WARN;
                            wcnt_q  <= '0;
                        end else begin
                            wcnt_q <= wcnt_q + 1'b1;
                        end
                    end else begin
                        wcnt_q <= '0;
                    end
                end
                WARN: begin
                    if (temp_q <= WARN_OFF_C) begin
                        if (wcnt_q >= DB_LAST) begin
                            state_q <= NORMAL;
                            wcnt_q  <= '0;
                        end else begin
                            wcnt_q <= wcnt_q + 1'b1;
                        end
                    end else begin
                        wcnt_q <= '0;
                    end
                end
                default: begin
                    state_q <= NORMAL;
                    wcnt_q  <= '0;
                end
            endcase
        end
    end

    // The clear is honoured only once the latest average is below the fault level.
    always_ff @(posedge CLK or negedge iRST) begin
        if (!iRST) begin
            fcnt_q  <= '0;
            fault_q <= 1'b0;
        end else if (iClear && !fault_set_d && (temp_q < FAULT_ON_C)) begin
            fcnt_q  <= '0;
            fault_q <= 1'b0;
        end else if (temp_valid_q) begin
            if (temp_q >= FAULT_ON_C) begin
                if (fcnt_q != DB_MAX) begin
                    fcnt_q <= fcnt_q + 1'b1;
                end
                if (fcnt_q >= DB_LAST) begin
                    fault_q <= 1'b1;
                end
            end else begin
                fcnt_q <= '0;
            end
        end
    end

    assign oTemp       = temp_q;
    assign oTemp_valid = temp_valid_q;
    assign oWarn       = (state_q == WARN);
    assign oFault      = fault_q;
    assign oLost       = lost_q;
    assign oTrip       = fault_q | lost_q;
endmodule

// File: tb/tb_apwm_temp_monitor.sv
// Directed bench for apwm_temp_monitor. The stimulus pushes each expected average and its
// sampling edge into a queue, and a monitor pops and checks every oTemp_valid pulse.
module tb_apwm_temp_monitor;
    logic       CLK = 1'b0;
    logic       iRST;
    logic [9:0] iDuty;
    logic       iDuty_valid;
    logic       iClear;
    logic [9:0] oTemp;
    logic       oTemp_valid, oWarn, oFault, oLost, oTrip;

    apwm_temp_monitor #(.TIMEOUT(1000)) dut (
        .CLK(CLK), .iRST(iRST), .iDuty(iDuty), .iDuty_valid(iDuty_valid), .iClear(iClear),
        .oTemp(oTemp), .oTemp_valid(oTemp_valid), .oWarn(oWarn), .oFault(oFault),
        .oLost(oLost), .oTrip(oTrip)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [9:0] temp;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   last_edge = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        exp_t e;
        if (iRST && oTemp_valid) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_valid: got oTemp=%0d at cycle %0d, expected no pulse", oTemp, cyc);
            end else begin
                e = sb.pop_front();
                if (oTemp !== e.temp || cyc != e.cyc) begin
                    n_err++;
                    $display("FAIL avg: got oTemp=%0d at cycle %0d, expected %0d at cycle %0d",
                             oTemp, cyc, e.temp, e.cyc);
                end else begin
                    $display("avg ok: oTemp=%0d at cycle %0d", oTemp, cyc);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end else begin
            $display("check %s: %0d", name, act);
        end
    endtask

    // One strobe followed by an idle gap (10 cycles per sample).
    task automatic strobe(input logic [9:0] d, input bit last, input logic [9:0] exp, input bit clr);
        @(posedge CLK); #1;
        iDuty = d;
        iDuty_valid = 1'b1;
        @(posedge CLK); #1;
        iDuty_valid = 1'b0;
        last_edge = cyc;
        if (last) begin
            sb.push_back('{exp, cyc});
            if (clr) begin
                iClear = 1'b1;
                @(posedge CLK); #1;
                iClear = 1'b0;
            end
        end
        repeat (8) @(posedge CLK);
    endtask

    task automatic block(input logic [9:0] v, input bit clr);
        for (int i = 0; i < 7; i++) strobe(v, 1'b0, '0, 1'b0);
        strobe(v, 1'b1, v, clr);
    endtask

    task automatic pulse_clear();
        @(posedge CLK); #1;
        iClear = 1'b1;
        @(posedge CLK); #1;
        iClear = 1'b0;
        @(negedge CLK);
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) begin
            @(posedge CLK); #1;
        end
    endtask

    task automatic chk_flags(input string name, input bit w, input bit f, input bit l);
        @(negedge CLK);
        chk({name, "_warn"}, oWarn, w);
        chk({name, "_fault"}, oFault, f);
        chk({name, "_lost"}, oLost, l);
        chk({name, "_trip"}, oTrip, f | l);
    endtask

    initial begin
        iRST = 1'b0;
        iDuty = '0;
        iDuty_valid = 1'b0;
        iClear = 1'b0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("rst_temp", oTemp, 0);
        chk("rst_valid", oTemp_valid, 0);
        chk_flags("rst", 0, 0, 0);
        @(posedge CLK); #1;
        iRST = 1'b1;

        // Basic average and latency
        block(10'd500, 1'b0);
        chk_flags("t1", 0, 0, 0);

        // Truncation and full-scale
        for (int i = 0; i < 7; i++) strobe(10'd100, 1'b0, '0, 1'b0);
        strobe(10'd107, 1'b1, 10'd100, 1'b0);
        block(10'd1023, 1'b0);
        block(10'd500, 1'b0);
        chk_flags("t2", 0, 0, 0);

        // Hysteresis
        for (int i = 0; i < 4; i++) begin
            block(10'd720, 1'b0);
            @(negedge CLK);
            chk("warn_rise", oWarn, (i == 3));
        end
        for (int i = 0; i < 3; i++) block(10'd600, 1'b0);
        block(10'd680, 1'b0);
        chk_flags("warn_restart", 1, 0, 0);
        for (int i = 0; i < 4; i++) begin
            block(10'd600, 1'b0);
            @(negedge CLK);
            chk("warn_fall", oWarn, (i != 3));
        end
        for (int i = 0; i < 3; i++) block(10'd720, 1'b0);
        block(10'd600, 1'b0);
        chk_flags("warn_norise", 0, 0, 0);

        // Fault set, refused clear, accepted clear, clear coincident with set
        for (int i = 0; i < 4; i++) begin
            block(10'd900, 1'b0);
            @(negedge CLK);
            chk("fault_set", oFault, (i == 3));
        end
        chk_flags("fault_on", 1, 1, 0);
        pulse_clear();
        chk("fault_clr_hot", oFault, 1);
        block(10'd600, 1'b0);
        pulse_clear();
        chk("fault_clr_cool", oFault, 0);
        chk("trip_clr", oTrip, 0);
        for (int i = 0; i < 3; i++) block(10'd900, 1'b0);
        block(10'd900, 1'b1);
        chk_flags("fault_set_vs_clr", 1, 1, 0);
        block(10'd600, 1'b0);
        pulse_clear();
        chk("fault_clr2", oFault, 0);

        // Watchdog
        for (int i = 0; i < 3; i++) strobe(10'd100, 1'b0, '0, 1'b0);
        wait_until(last_edge + 999);
        @(negedge CLK);
        chk("lost_early", oLost, 0);
        @(posedge CLK); #1;
        @(negedge CLK);
        chk("lost_at_timeout", oLost, 1);
        chk("trip_lost", oTrip, 1);
        pulse_clear();
        chk("lost_clr_ignored", oLost, 1);
        strobe(10'd300, 1'b0, '0, 1'b0);
        pulse_clear();
        chk("lost_clr", oLost, 0);
        for (int i = 0; i < 6; i++) strobe(10'd300, 1'b0, '0, 1'b0);
        strobe(10'd300, 1'b1, 10'd300, 1'b0);
        wait_until(last_edge + 998);
        strobe(10'd900, 1'b0, '0, 1'b0);
        @(negedge CLK);
        chk("strobe_at_timeout", oLost, 0);
        for (int i = 0; i < 6; i++) strobe(10'd900, 1'b0, '0, 1'b0);
        strobe(10'd900, 1'b1, 10'd900, 1'b0);
        for (int i = 0; i < 3; i++) block(10'd900, 1'b0);
        chk_flags("pre_reset", 1, 1, 0);

        // Asynchronous reset mid-block
        for (int i = 0; i < 3; i++) strobe(10'd500, 1'b0, '0, 1'b0);
        @(posedge CLK); #3;
        iRST = 1'b0;
        #1;
        chk("arst_temp", oTemp, 0);
        chk("arst_valid", oTemp_valid, 0);
        chk("arst_warn", oWarn, 0);
        chk("arst_fault", oFault, 0);
        chk("arst_trip", oTrip, 0);
        repeat (2) @(posedge CLK);
        #1;
        iRST = 1'b1;
        block(10'd500, 1'b0);
        chk_flags("post_reset", 0, 0, 0);

        repeat (5) @(posedge CLK);
        chk("sb_drain", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/apwm_temp_monitor.md
Name: apwm_temp_monitor

Overview:
Downstream consumer of the UCC21750 driver block's APWM duty measurement. It takes per-period duty codes (larger code = hotter), block-averages them, and applies debounced hysteresis warning and latched over-temperature fault thresholds. A watchdog flags loss of the APWM stream. It produces a trip signal that the PWM/driver enable path uses to force the gate driver off.

Parameters:
DW, 10, duty code width
AVG_LOG2, 3, averaging block of 2^AVG_LOG2 samples
WARN_ON, 700, warning assert threshold (inclusive, >=)
WARN_OFF, 650, warning release threshold (inclusive, <=); must be < WARN_ON
FAULT_ON, 850, fault threshold (inclusive, >=)
DEBOUNCE, 4, consecutive averages required for any state change (>=1)
TIMEOUT, 2000000, clock cycles without a sample before stream-loss (20 ms at 100 MHz)
TW, 22, watchdog counter width; 2^TW > TIMEOUT

Ports:
CLK  in  1  system clock
iRST  in  1  reset, asynchronous, active-low
iDuty  in  DW  duty code from the APWM measurement stage
iDuty_valid  in  1  single-cycle strobe; iDuty is sampled when high
iClear  in  1  single-cycle fault-clear request
oTemp  out  DW  latest block average
oTemp_valid  out  1  one-cycle pulse when oTemp updates
oWarn  out  1  warning state (hysteretic)
oFault  out  1  latched over-temperature fault
oLost  out  1  latched APWM stream-loss fault
oTrip  out  1  oFault | oLost (OR of registered signals)

Behaviour:
- Reset: iRST low asynchronously clears accumulator, sample count, debounce counters, watchdog, and oTemp. All outputs go to 0 and the state goes to NORMAL.
- Averager: accumulator is DW+AVG_LOG2 bits wide and cannot overflow. Each valid sample is added and the count is incremented.
- On the 2^AVG_LOG2-th sample, oTemp <= (acc+iDuty)>>AVG_LOG2 (truncated) and oTemp_valid pulses on the next cycle (1-cycle latency). The accumulator restarts from 0.
- Averaging is block-based, not sliding. No output is produced before the first full block.
- Warn FSM, states NORMAL and WARN, evaluated only on oTemp_valid:
  - NORMAL: oTemp >= WARN_ON increments the debounce counter; any other value zeroes it. At DEBOUNCE the FSM goes to WARN and the counter clears.
  - WARN: oTemp <= WARN_OFF increments the counter; any other value zeroes it. At DEBOUNCE the FSM goes to NORMAL.
  - oWarn = (state == WARN), registered. It updates on the same edge that consumes the DEBOUNCE-th qualifying average.
- Fault: a separate debounce counter counts consecutive averages with oTemp >= FAULT_ON. At DEBOUNCE, oFault sets and stays set.
  - iClear clears oFault only if the latest oTemp < FAULT_ON. Otherwise the clear is ignored.
  - Clearing resets the fault debounce counter.
- Watchdog: the counter resets on iDuty_valid and otherwise increments, saturating.
  - oLost sets on the edge where TIMEOUT consecutive cycles without valid have elapsed.
  - The same edge discards any partial block (accumulator and count cleared). oTemp holds its last value.
- oLost clear: iClear clears oLost only if at least one valid sample has arrived since the loss. Otherwise it is ignored.
- Simultaneous events:
  - iDuty_valid on the timeout cycle: the valid wins and no loss is flagged.
  - A set condition and iClear on the same cycle: set wins.
  - A debounce count crossing while state changes: the FSM uses the pre-edge state.
- Counters: debounce counters are clog2(DEBOUNCE+1) bits and saturate. They are never reset by the loss event.
- oTrip is combinational OR of oFault and oLost. It has no glitch because both inputs are flops.

Test Plan:
1. Release reset, 8 samples of 500 spaced 10 cycles -> oTemp=500, oTemp_valid pulses exactly 1 cycle after the 8th strobe; oWarn=oFault=oLost=0.
2. Truncation: 7×100 plus 1×107 (sum 807) -> oTemp=100. 8×1023 -> oTemp=1023 with no overflow.
3. Hysteresis:
   - 4 blocks of 720 -> oWarn rises on the 4th oTemp_valid.
   - 3 blocks of 600 then 1 block of 680 -> oWarn stays 1 (debounce restarts).
   - 4 blocks of 600 -> oWarn falls on the 4th.
   - 3 blocks of 720 then 600 -> oWarn never rises.
4. Fault:
   - 4 blocks of 900 -> oFault=oTrip=1 (oWarn also 1).
   - iClear while last oTemp=900 -> oFault stays 1.
   - 1 block of 600 then iClear -> oFault=0 next cycle.
   - iClear on the same cycle as the 4th 900 average -> oFault=1.
5. Watchdog (TIMEOUT=1000 in bench):
   - 3 samples, then silence -> oLost=1 exactly 1000 cycles after the last strobe.
   - The next 8 samples form a fresh block; the 3 old samples are excluded from the average.
   - iClear before any new sample -> ignored; iClear after a sample -> oLost=0.
   - A strobe on cycle 1000 -> no loss.
6. Assert iRST low mid-block with oWarn=oFault=1 -> all outputs 0 asynchronously. After release, a full 8-sample block is needed before oTemp_valid.
